// File: rtl/keypad_scanner_param.sv
// ROWS x COLS keypad scanner: row strobe, col sync, frame debounce.
// Emits press/release pulses and flags multi-key frames.
module keypad_scanner_param #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 24000,
  parameter int DEBOUNCE = 4,
  parameter int CODE_W   = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_press,
  output logic              key_release,
  output logic              multi_key
);

  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(DEBOUNCE+1);

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_t;

  logic [COLS-1:0]   sync1, sync2;
  logic              run;
  logic [DW-1:0]     div;
  logic [RW-1:0]     ridx, ridx_nxt;
  logic [1:0]        acc_n;
  logic [CODE_W-1:0] acc_code;
  res_t              prev_cls, cur_cls;
  logic [CODE_W-1:0] prev_code;
  logic [SW-1:0]     stable, stable_nxt;

  logic              sample, frame_end;
  logic [1:0]        hit_n, tot;
  logic [2:0]        sum;
  logic [CW-1:0]     hit_idx;
  logic [CODE_W-1:0] row_code, first_code;
  res_t              res_cls;
  logic              same, accept;

  assign sample    = run && (div == DW'(SCAN_DIV-1));
  assign frame_end = sample && (ridx == RW'(ROWS-1));

  always_comb begin
    hit_n   = 2'd0;
    hit_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!sync2[c]) begin
        if (hit_n == 2'd0) hit_idx = CW'(c);
        if (hit_n != 2'd2) hit_n = hit_n + 2'd1;
      end
    end
  end

  // Frame accumulator: saturating hit count plus first hit in scan order.
  always_comb begin
    sum        = {1'b0, acc_n} + {1'b0, hit_n};
    tot        = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    row_code   = CODE_W'(int'(ridx)*COLS + int'(hit_idx));
    first_code = (acc_n == 2'd0) ? row_code : acc_code;
    res_cls    = res_t'(tot);
  end

  always_comb begin
    same = (res_cls == prev_cls) &&
           (res_cls != RES_SINGLE || first_code == prev_code);
    stable_nxt = SW'(1);
    if (same) begin
      stable_nxt = (stable == SW'(DEBOUNCE)) ? stable
                                             : stable + SW'(1);
    end
    accept = (stable_nxt == SW'(DEBOUNCE)) &&
             ((res_cls != cur_cls) ||
              (res_cls == RES_SINGLE && first_code != key_code));
  end

  always_comb begin
    ridx_nxt = ridx;
    if (sample) begin
      ridx_nxt = (ridx == RW'(ROWS-1)) ? '0 : ridx + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '1;
      sync2       <= '1;
      run         <= 1'b0;
      div         <= '0;
      ridx        <= '0;
      row         <= '1;
      acc_n       <= 2'd0;
      acc_code    <= '0;
      prev_cls    <= RES_NONE;
      prev_code   <= '0;
      stable      <= '0;
      cur_cls     <= RES_NONE;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      sync1       <= col;
      sync2       <= sync1;
      run         <= 1'b1;
      ridx        <= ridx_nxt;
      row         <= ~(ROWS'(1) << ridx_nxt);
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (run) begin
        div <= (div == DW'(SCAN_DIV-1)) ? '0 : div + DW'(1);
      end
      if (frame_end) begin
        acc_n     <= 2'd0;
        acc_code  <= '0;
        prev_cls  <= res_cls;
        prev_code <= first_code;
        stable    <= stable_nxt;
        if (accept) begin
          cur_cls     <= res_cls;
          key_valid   <= (res_cls == RES_SINGLE);
          multi_key   <= (res_cls == RES_MULTI);
          key_press   <= (res_cls == RES_SINGLE);
          key_release <= (cur_cls == RES_SINGLE) &&
                         (res_cls != RES_SINGLE);
          if (res_cls == RES_SINGLE) key_code <= first_code;
        end
      end else if (sample) begin
        acc_n    <= tot;
        acc_code <= first_code;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Bench for keypad_scanner_param: key-set model checked every clock.
// Directed scenarios followed by random key sets.
module tb_keypad_scanner_param;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_press;
  logic       key_release;
  logic       multi_key;

  logic [15:0] pressed;
  logic        col_zero;

  int n_assert;
  int n_fail;
  int n_press;
  int n_rel;

  int mt;
  int fkeys[$];
  int hist[$];
  int macc;
  logic       e_valid;
  logic [3:0] e_code;
  logic       e_press;
  logic       e_rel;
  logic       e_multi;

  keypad_scanner_param #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col(col),
    .row(row),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_press(key_press),
    .key_release(key_release),
    .multi_key(multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    if (col_zero) col = 4'h0;
    else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mt = -1;
    fkeys.delete();
    hist.delete();
    macc = 0;
    e_valid = 0; e_code = 0; e_press = 0; e_rel = 0; e_multi = 0;
  endtask

  task automatic model_frame_end();
    int n, res, st;
    n = fkeys.size();
    if (n == 0) res = 0;
    else if (n == 1) res = fkeys[0] + 1;
    else res = 100;
    fkeys.delete();
    hist.push_back(res);
    if (hist.size() > 3) void'(hist.pop_front());
    st = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != res) break;
      st++;
    end
    if (st == 3 && res != macc) begin
      e_valid = (res >= 1 && res <= 16);
      e_multi = (res == 100);
      e_press = e_valid;
      e_rel   = (macc >= 1 && macc <= 16) && !e_valid;
      if (e_valid) e_code = 4'(res - 1);
      macc = res;
    end
  endtask

  task automatic step();
    logic        was_rst;
    logic [15:0] snap;
    logic [3:0]  er;
    int old, r;
    was_rst = rst;
    snap = pressed;
    @(posedge clk);
    #1;
    if (was_rst) model_reset();
    else begin
      old = mt;
      mt++;
      e_press = 0;
      e_rel = 0;
      // Column state seen two clocks before the row's sample point.
      if (old >= 0 && old % 4 == 1) begin
        r = (old / 4) % 4;
        for (int c = 0; c < 4; c++)
          if (snap[r*4+c]) fkeys.push_back(r*4+c);
      end
      if (old >= 0 && old % 16 == 15) model_frame_end();
    end
    er = 4'hF;
    if (mt >= 0) er[(mt/4)%4] = 1'b0;
    chk("row", 32'(row), 32'(er));
    chk("key_valid", 32'(key_valid), 32'(e_valid));
    chk("key_code", 32'(key_code), 32'(e_code));
    chk("key_press", 32'(key_press), 32'(e_press));
    chk("key_release", 32'(key_release), 32'(e_rel));
    chk("multi_key", 32'(multi_key), 32'(e_multi));
    if (key_press) n_press++;
    if (key_release) n_rel++;
  endtask

  task automatic wait_pulse(input bit want_press,
                            input int budget,
                            output int waited);
    logic seen;
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < budget) begin
      step();
      waited++;
      seen = want_press ? key_press : key_release;
    end
    chk(want_press ? "press_timeout" : "release_timeout",
        32'(seen), 32'd1);
  endtask

  task automatic align();
    int k;
    k = 0;
    while (mt % 16 != 0 && k < 20) begin
      step();
      k++;
    end
  endtask

  initial begin
    int w, p0, r0, n, idx;
    n_assert = 0; n_fail = 0; n_press = 0; n_rel = 0;
    model_reset();
    pressed = '0;
    col_zero = 1'b1;
    rst = 1'b1;

    // 1: reset with col forced low, then the row walk
    repeat (3) step();
    chk("reset_row", 32'(row), 32'hF);
    rst = 1'b0;
    col_zero = 1'b0;
    repeat (20) step();

    // 2: single key r2 c1
    align();
    pressed[9] = 1'b1;
    wait_pulse(1, 100, w);
    chk("press9_code", 32'(key_code), 32'd9);
    chk("press9_valid", 32'(key_valid), 32'd1);
    chk("press9_latency", 32'(w >= 48 && w <= 67), 32'd1);
    p0 = n_press; r0 = n_rel;
    repeat (160) step();
    chk("hold_no_press", 32'(n_press - p0), 32'd0);
    chk("hold_no_release", 32'(n_rel - r0), 32'd0);
    pressed = '0;
    wait_pulse(0, 100, w);
    chk("rel9_valid", 32'(key_valid), 32'd0);
    chk("rel9_code", 32'(key_code), 32'd9);

    // 3: bounce on key 0 every 1.5 frames
    align();
    p0 = n_press; r0 = n_rel;
    for (int k = 0; k < 128; k++) begin
      if (k % 24 == 0) pressed[0] = ~pressed[0];
      step();
    end
    chk("bounce_no_press", 32'(n_press - p0), 32'd0);
    chk("bounce_no_release", 32'(n_rel - r0), 32'd0);
    pressed[0] = 1'b1;
    wait_pulse(1, 100, w);
    chk("bounce_code", 32'(key_code), 32'd0);
    chk("bounce_one_press", 32'(n_press - p0), 32'd1);
    pressed = '0;
    wait_pulse(0, 100, w);

    // 4: multi-key entry and exit
    pressed[5] = 1'b1;
    wait_pulse(1, 100, w);
    chk("multi_pre_code", 32'(key_code), 32'd5);
    pressed[10] = 1'b1;
    wait_pulse(0, 100, w);
    chk("multi_valid", 32'(key_valid), 32'd0);
    chk("multi_flag", 32'(multi_key), 32'd1);
    chk("multi_code_hold", 32'(key_code), 32'd5);
    pressed[10] = 1'b0;
    wait_pulse(1, 100, w);
    chk("multi_back_code", 32'(key_code), 32'd5);
    chk("multi_back_flag", 32'(multi_key), 32'd0);
    pressed = '0;
    wait_pulse(0, 100, w);

    // 5: rollover 3 -> 12
    pressed[3] = 1'b1;
    wait_pulse(1, 100, w);
    chk("roll_first", 32'(key_code), 32'd3);
    r0 = n_rel;
    pressed = '0;
    pressed[12] = 1'b1;
    wait_pulse(1, 100, w);
    chk("roll_code", 32'(key_code), 32'd12);
    chk("roll_valid", 32'(key_valid), 32'd1);
    chk("roll_no_release", 32'(n_rel - r0), 32'd0);

    // 6: reset mid-frame while a key is accepted
    align();
    repeat (8) step();
    r0 = n_rel;
    rst = 1'b1;
    step();
    step();
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_row", 32'(row), 32'hF);
    rst = 1'b0;
    wait_pulse(1, 100, w);
    chk("post_rst_code", 32'(key_code), 32'd12);
    chk("mid_rst_no_release", 32'(n_rel - r0), 32'd0);

    // 7: random key sets held for random spans
    for (int it = 0; it < 30; it++) begin
      pressed = '0;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        idx = $urandom_range(0, 15);
        pressed[idx] = 1'b1;
      end
      repeat ($urandom_range(5, 90)) step();
    end
    pressed = '0;
    repeat (80) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
